// File: rtl/mem_pipeline_q.sv
// Queued memory micro-op pipeline: in-order FIFO of load/store/clflush ops feeding the data cache.
// Optional feature macro MPIPE_BADOP_TRAP_EN: retire unknown opcodes without a cache request.

package DecoderTypes;
   typedef enum logic [3:0] {
      m_nop     = 4'd0,
      m_alu     = 4'd1,
      m_ld      = 4'd2,
      m_st      = 4'd3,
      m_clflush = 4'd4
   } opcode_t;

   typedef struct packed {
      logic [63:0] val;
   } operand_t;

   typedef struct packed {
      opcode_t    op;
      logic [7:0] tag;
      operand_t   dst_val;
      operand_t   src0_val;
      operand_t   src1_val;
   } micro_op_t;
endpackage

package CACHE;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      FLUSH = 2'd3
   } cache_cmd_t;
endpackage

module mem_pipeline_q #(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_ready,
   input  DecoderTypes::micro_op_t in_mop,
   output logic                    busy,
   output logic [CNT_W-1:0]        count,
   output logic                    out_ready,
   output DecoderTypes::micro_op_t out_mop,
   input  logic                    out_stall,
   output logic                    badop,
   output CACHE::cache_cmd_t       ca_req_cmd,
   output logic [63:0]             ca_req_addr,
   output logic [63:0]             ca_req_data,
   input  logic                    ca_respcyc,
   input  logic [63:0]             ca_resp_data
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   DecoderTypes::micro_op_t mem [DEPTH];
   DecoderTypes::micro_op_t head;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count_next;
   state_t                  state;
   state_t                  state_next;
   logic                    push;
   logic                    pop;
   logic                    slot_free;
   logic                    head_bad;
   logic                    issue;
   logic                    retire_bad;
   logic                    req_active;
   logic                    resp_take;

`ifdef MPIPE_BADOP_TRAP_EN
   function automatic logic is_mem_op(input DecoderTypes::opcode_t op);
      return (op == DecoderTypes::m_ld) || (op == DecoderTypes::m_st) ||
             (op == DecoderTypes::m_clflush);
   endfunction

   assign head_bad = !is_mem_op(head.op);
`else
   assign head_bad = 1'b0;
`endif

   // The request is presented in the same cycle the slot frees, so a draining
   // output overlaps with the next issue; once in ST_REQ the slot is empty.
   assign head       = mem[rd_ptr];
   assign slot_free  = !out_ready || !out_stall;
   assign issue      = (state == ST_IDLE) && (count != '0) && slot_free && !head_bad;
   assign retire_bad = (state == ST_IDLE) && (count != '0) && slot_free && head_bad;
   assign req_active = (state == ST_REQ) || issue;
   assign resp_take  = req_active && ca_respcyc;
   assign push       = in_ready && !busy;
   assign pop        = resp_take || retire_bad;
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (issue && !ca_respcyc) state_next = ST_REQ;
         ST_REQ:  if (ca_respcyc)           state_next = ST_IDLE;
         default:                           state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ca_req_cmd  = CACHE::IDLE;
      ca_req_addr = '0;
      ca_req_data = '0;
      if (req_active) begin
         ca_req_addr = head.src0_val.val;
         case (head.op)
            DecoderTypes::m_ld:      ca_req_cmd = CACHE::READ;
            DecoderTypes::m_st: begin
               ca_req_cmd  = CACHE::WRITE;
               ca_req_addr = head.src1_val.val;
               ca_req_data = head.src0_val.val;
            end
            DecoderTypes::m_clflush: ca_req_cmd = CACHE::FLUSH;
            default:                 ca_req_cmd = CACHE::READ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         busy   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         busy  <= (count_next == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_mop;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          out_ready <= 1'b0;
      else if (pop)        out_ready <= 1'b1;
      else if (!out_stall) out_ready <= 1'b0;
   end

   // Retired ops carry their cache response, or all-ones when trapped.
   always_ff @(posedge clk) begin
      if (pop) begin
         out_mop             <= head;
         out_mop.dst_val.val <= resp_take ? ca_resp_data : '1;
      end
   end

`ifdef MPIPE_BADOP_TRAP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) badop <= 1'b0;
      else        badop <= retire_bad;
   end
`else
   assign badop = 1'b0;
`endif

endmodule

// File: tb/tb_mem_pipeline_q.sv
// Directed self-checking bench for mem_pipeline_q (DEPTH=4); inputs change on negedge, outputs checked 1 unit later.
module tb_mem_pipeline_q;
   import DecoderTypes::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_ready = 1'b0;
   logic              out_stall = 1'b0;
   logic              ca_respcyc = 1'b0;
   logic [63:0]       ca_resp_data = 64'h0;
   micro_op_t         in_mop;
   micro_op_t         out_mop;
   logic              busy;
   logic              out_ready;
   logic              badop;
   logic [CNT_W-1:0]  count;
   CACHE::cache_cmd_t ca_req_cmd;
   logic [63:0]       ca_req_addr;
   logic [63:0]       ca_req_data;
   int                n_chk = 0;
   int                n_fail = 0;

   always #5 clk = ~clk;

   mem_pipeline_q #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_ready(in_ready), .in_mop(in_mop),
      .busy(busy), .count(count), .out_ready(out_ready), .out_mop(out_mop),
      .out_stall(out_stall), .badop(badop), .ca_req_cmd(ca_req_cmd),
      .ca_req_addr(ca_req_addr), .ca_req_data(ca_req_data),
      .ca_respcyc(ca_respcyc), .ca_resp_data(ca_resp_data)
   );

   function automatic micro_op_t mk(input opcode_t op, input logic [7:0] tag,
                                    input logic [63:0] s0, input logic [63:0] s1);
      micro_op_t m;
      m.op = op;
      m.tag = tag;
      m.dst_val.val = 64'h0;
      m.src0_val.val = s0;
      m.src1_val.val = s1;
      return m;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      in_mop = mk(m_nop, 8'd0, 64'h0, 64'h0);
      repeat (2) @(negedge clk);
      #1;
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_chk++; if (out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_out_ready got %b exp 0", out_ready); end
      n_chk++; if (badop !== 1'b0) begin n_fail++; $display("FAIL reset_badop got %b exp 0", badop); end
      n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL reset_cmd got %0d exp %0d", ca_req_cmd, CACHE::IDLE); end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_single_load();
      @(negedge clk); in_ready = 1'b1; in_mop = mk(m_ld, 8'd1, 64'h1000, 64'h0); #1;
      n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL single_pre_cmd got %0d exp %0d", ca_req_cmd, CACHE::IDLE); end
      @(negedge clk); in_ready = 1'b0; #1;
      n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
      n_chk++; if (ca_req_cmd !== CACHE::READ) begin n_fail++; $display("FAIL single_cmd got %0d exp %0d", ca_req_cmd, CACHE::READ); end
      n_chk++; if (ca_req_addr !== 64'h1000) begin n_fail++; $display("FAIL single_addr got %h exp %h", ca_req_addr, 64'h1000); end
      n_chk++; if (ca_req_data !== 64'h0) begin n_fail++; $display("FAIL single_data got %h exp 0", ca_req_data); end
      @(negedge clk); #1;
      n_chk++; if (ca_req_cmd !== CACHE::READ) begin n_fail++; $display("FAIL single_hold_cmd got %0d exp %0d", ca_req_cmd, CACHE::READ); end
      @(negedge clk); ca_respcyc = 1'b1; ca_resp_data = 64'hDEAD_BEEF; #1;
      n_chk++; if (out_ready !== 1'b0) begin n_fail++; $display("FAIL single_early_out got %b exp 0", out_ready); end
      @(negedge clk); ca_respcyc = 1'b0; #1;
      n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL single_out_ready got %b exp 1", out_ready); end
      n_chk++; if (out_mop.dst_val.val !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL single_dst got %h exp %h", out_mop.dst_val.val, 64'hDEAD_BEEF); end
      n_chk++; if (out_mop.tag !== 8'd1) begin n_fail++; $display("FAIL single_tag got %0d exp 1", out_mop.tag); end
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count_after got %0d exp 0", count); end
      n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL single_cmd_after got %0d exp %0d", ca_req_cmd, CACHE::IDLE); end
      @(negedge clk); #1;
      n_chk++; if (out_ready !== 1'b0) begin n_fail++; $display("FAIL single_consumed got %b exp 0", out_ready); end
   endtask

   task automatic test_fill_order();
      micro_op_t         ops   [4];
      CACHE::cache_cmd_t cmds  [4];
      logic [63:0]       addrs [4];
      logic [63:0]       datas [4];
      ops[0] = mk(m_st,      8'd2, 64'h55, 64'h20); cmds[0] = CACHE::WRITE; addrs[0] = 64'h20; datas[0] = 64'h55;
      ops[1] = mk(m_ld,      8'd3, 64'h40, 64'h0);  cmds[1] = CACHE::READ;  addrs[1] = 64'h40; datas[1] = 64'h0;
      ops[2] = mk(m_clflush, 8'd4, 64'h60, 64'h0);  cmds[2] = CACHE::FLUSH; addrs[2] = 64'h60; datas[2] = 64'h0;
      ops[3] = mk(m_ld,      8'd5, 64'h80, 64'h0);  cmds[3] = CACHE::READ;  addrs[3] = 64'h80; datas[3] = 64'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); in_ready = 1'b1; in_mop = ops[i]; #1;
         n_chk++; if (count !== CNT_W'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
      end
      @(negedge clk); in_mop = mk(m_ld, 8'd99, 64'hF0, 64'h0); #1;
      n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_full_count got %0d exp 4", count); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy got %b exp 1", busy); end
      n_chk++; if (ca_req_cmd !== cmds[0]) begin n_fail++; $display("FAIL fill_cmd0 got %0d exp %0d", ca_req_cmd, cmds[0]); end
      n_chk++; if (ca_req_addr !== addrs[0]) begin n_fail++; $display("FAIL fill_addr0 got %h exp %h", ca_req_addr, addrs[0]); end
      n_chk++; if (ca_req_data !== datas[0]) begin n_fail++; $display("FAIL fill_data0 got %h exp %h", ca_req_data, datas[0]); end
      @(negedge clk); in_ready = 1'b0; #1;
      n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_drop_count got %0d exp 4", count); end
      for (int i = 0; i < 4; i++) begin
         ca_respcyc = 1'b1; ca_resp_data = 64'h100 + 64'(i);
         @(negedge clk); ca_respcyc = 1'b0; #1;
         n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL fill_out_ready[%0d] got %b exp 1", i, out_ready); end
         n_chk++; if (out_mop.tag !== ops[i].tag) begin n_fail++; $display("FAIL fill_tag[%0d] got %0d exp %0d", i, out_mop.tag, ops[i].tag); end
         n_chk++; if (out_mop.dst_val.val !== 64'h100 + 64'(i)) begin n_fail++; $display("FAIL fill_dst[%0d] got %h exp %h", i, out_mop.dst_val.val, 64'h100 + 64'(i)); end
         n_chk++; if (count !== CNT_W'(3 - i)) begin n_fail++; $display("FAIL fill_drain_count[%0d] got %0d exp %0d", i, count, 3 - i); end
         if (i < 3) begin
            n_chk++; if (ca_req_cmd !== cmds[i+1]) begin n_fail++; $display("FAIL fill_cmd[%0d] got %0d exp %0d", i + 1, ca_req_cmd, cmds[i+1]); end
            n_chk++; if (ca_req_addr !== addrs[i+1]) begin n_fail++; $display("FAIL fill_addr[%0d] got %h exp %h", i + 1, ca_req_addr, addrs[i+1]); end
            n_chk++; if (ca_req_data !== datas[i+1]) begin n_fail++; $display("FAIL fill_data[%0d] got %h exp %h", i + 1, ca_req_data, datas[i+1]); end
         end else begin
            n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL fill_final_cmd got %0d exp %0d", ca_req_cmd, CACHE::IDLE); end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_pressure();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_ready = 1'b1; in_mop = mk(m_ld, 8'(10 + i), 64'h200 + 64'(8 * i), 64'h0);
      end
      @(negedge clk); in_ready = 1'b0; #1;
      n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL bp_count got %0d exp 3", count); end
      n_chk++; if (ca_req_addr !== 64'h200) begin n_fail++; $display("FAIL bp_addr0 got %h exp %h", ca_req_addr, 64'h200); end
      ca_respcyc = 1'b1; ca_resp_data = 64'hAAAA;
      @(negedge clk); ca_respcyc = 1'b0; out_stall = 1'b1; #1;
      n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL bp_out_ready got %b exp 1", out_ready); end
      n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL bp_stall_cmd got %0d exp %0d", ca_req_cmd, CACHE::IDLE); end
      for (int k = 1; k < 5; k++) begin
         @(negedge clk); #1;
         n_chk++; if (out_ready !== 1'b1 || out_mop.tag !== 8'd10 || out_mop.dst_val.val !== 64'hAAAA) begin
            n_fail++; $display("FAIL bp_hold[%0d] got rdy=%b tag=%0d dst=%h exp rdy=1 tag=10 dst=aaaa", k, out_ready, out_mop.tag, out_mop.dst_val.val);
         end
         n_chk++; if (count !== 3'd2) begin n_fail++; $display("FAIL bp_hold_count[%0d] got %0d exp 2", k, count); end
         n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL bp_hold_cmd[%0d] got %0d exp %0d", k, ca_req_cmd, CACHE::IDLE); end
      end
      @(negedge clk); out_stall = 1'b0; #1;
      n_chk++; if (out_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got %b exp 1", out_ready); end
      n_chk++; if (ca_req_cmd !== CACHE::READ) begin n_fail++; $display("FAIL bp_release_cmd got %0d exp %0d", ca_req_cmd, CACHE::READ); end
      n_chk++; if (ca_req_addr !== 64'h208) begin n_fail++; $display("FAIL bp_release_addr got %h exp %h", ca_req_addr, 64'h208); end
      ca_respcyc = 1'b1; ca_resp_data = 64'hBBBB;
      @(negedge clk); #1;
      ca_respcyc = 1'b0;
      n_chk++; if (out_mop.tag !== 8'd11 || out_mop.dst_val.val !== 64'hBBBB) begin n_fail++; $display("FAIL bp_second got tag=%0d dst=%h exp tag=11 dst=bbbb", out_mop.tag, out_mop.dst_val.val); end
      n_chk++; if (ca_req_addr !== 64'h210) begin n_fail++; $display("FAIL bp_third_addr got %h exp %h", ca_req_addr, 64'h210); end
      ca_respcyc = 1'b1; ca_resp_data = 64'hCCCC;
      @(negedge clk); ca_respcyc = 1'b0; #1;
      n_chk++; if (out_mop.tag !== 8'd12 || count !== 3'd0) begin n_fail++; $display("FAIL bp_third got tag=%0d count=%0d exp tag=12 count=0", out_mop.tag, count); end
      @(negedge clk);
   endtask

   task automatic test_simul_enq_deq();
      @(negedge clk); in_ready = 1'b1; in_mop = mk(m_ld, 8'd20, 64'h300, 64'h0);
      @(negedge clk); in_mop = mk(m_ld, 8'd21, 64'h308, 64'h0);
      @(negedge clk); in_ready = 1'b0; #1;
      n_chk++; if (count !== 3'd2) begin n_fail++; $display("FAIL sim_count got %0d exp 2", count); end
      n_chk++; if (ca_req_addr !== 64'h300) begin n_fail++; $display("FAIL sim_addr0 got %h exp %h", ca_req_addr, 64'h300); end
      ca_respcyc = 1'b1; ca_resp_data = 64'h1; in_ready = 1'b1; in_mop = mk(m_ld, 8'd22, 64'h310, 64'h0);
      @(negedge clk); ca_respcyc = 1'b0; in_ready = 1'b0; #1;
      n_chk++; if (count !== 3'd2) begin n_fail++; $display("FAIL sim_count_same got %0d exp 2", count); end
      n_chk++; if (out_mop.tag !== 8'd20) begin n_fail++; $display("FAIL sim_tag0 got %0d exp 20", out_mop.tag); end
      n_chk++; if (ca_req_cmd !== CACHE::READ || ca_req_addr !== 64'h308) begin n_fail++; $display("FAIL sim_next got cmd=%0d addr=%h exp cmd=1 addr=308", ca_req_cmd, ca_req_addr); end
      ca_respcyc = 1'b1; ca_resp_data = 64'h2;
      @(negedge clk); ca_respcyc = 1'b0; #1;
      n_chk++; if (out_mop.tag !== 8'd21 || ca_req_addr !== 64'h310) begin n_fail++; $display("FAIL sim_second got tag=%0d addr=%h exp tag=21 addr=310", out_mop.tag, ca_req_addr); end
      ca_respcyc = 1'b1; ca_resp_data = 64'h3;
      @(negedge clk); ca_respcyc = 1'b0; #1;
      n_chk++; if (out_mop.tag !== 8'd22 || count !== 3'd0) begin n_fail++; $display("FAIL sim_third got tag=%0d count=%0d exp tag=22 count=0", out_mop.tag, count); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_request();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_ready = 1'b1; in_mop = mk(m_ld, 8'(40 + i), 64'h400 + 64'(8 * i), 64'h0);
      end
      @(negedge clk); in_ready = 1'b0; #1;
      n_chk++; if (count !== 3'd3 || ca_req_cmd !== CACHE::READ) begin n_fail++; $display("FAIL rst_pre got count=%0d cmd=%0d exp count=3 cmd=1", count, ca_req_cmd); end
      #1 reset = 1'b0; #1;
      n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL rst_cmd got %0d exp %0d", ca_req_cmd, CACHE::IDLE); end
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
      n_chk++; if (busy !== 1'b0 || out_ready !== 1'b0) begin n_fail++; $display("FAIL rst_flags got busy=%b rdy=%b exp busy=0 rdy=0", busy, out_ready); end
      @(negedge clk); reset = 1'b1; #1;
      n_chk++; if (ca_req_cmd !== CACHE::IDLE || count !== 3'd0) begin n_fail++; $display("FAIL rst_release got cmd=%0d count=%0d exp cmd=0 count=0", ca_req_cmd, count); end
   endtask

`ifdef MPIPE_BADOP_TRAP_EN
   task automatic test_badop();
      @(negedge clk); in_ready = 1'b1; in_mop = mk(m_alu, 8'd30, 64'h500, 64'h0); #1;
      n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL bad_pre_cmd got %0d exp 0", ca_req_cmd); end
      @(negedge clk); in_mop = mk(m_ld, 8'd31, 64'h100, 64'h0); #1;
      n_chk++; if (ca_req_cmd !== CACHE::IDLE) begin n_fail++; $display("FAIL bad_no_req got %0d exp 0", ca_req_cmd); end
      n_chk++; if (badop !== 1'b0) begin n_fail++; $display("FAIL bad_early_pulse got %b exp 0", badop); end
      @(negedge clk); in_ready = 1'b0; #1;
      n_chk++; if (out_ready !== 1'b1 || badop !== 1'b1) begin n_fail++; $display("FAIL bad_pulse got rdy=%b badop=%b exp rdy=1 badop=1", out_ready, badop); end
      n_chk++; if (out_mop.dst_val.val !== 64'hFFFF_FFFF_FFFF_FFFF || out_mop.tag !== 8'd30) begin n_fail++; $display("FAIL bad_dst got dst=%h tag=%0d exp dst=ffffffffffffffff tag=30", out_mop.dst_val.val, out_mop.tag); end
      n_chk++; if (ca_req_cmd !== CACHE::READ || ca_req_addr !== 64'h100) begin n_fail++; $display("FAIL bad_next got cmd=%0d addr=%h exp cmd=1 addr=100", ca_req_cmd, ca_req_addr); end
      ca_respcyc = 1'b1; ca_resp_data = 64'h77;
      @(negedge clk); ca_respcyc = 1'b0; #1;
      n_chk++; if (badop !== 1'b0) begin n_fail++; $display("FAIL bad_pulse_len got %b exp 0", badop); end
      n_chk++; if (out_mop.tag !== 8'd31 || out_mop.dst_val.val !== 64'h77) begin n_fail++; $display("FAIL bad_follow got tag=%0d dst=%h exp tag=31 dst=77", out_mop.tag, out_mop.dst_val.val); end
      @(negedge clk);
   endtask
`else
   task automatic test_unknown_opcode();
      @(negedge clk); in_ready = 1'b1; in_mop = mk(m_alu, 8'd30, 64'h500, 64'h0);
      @(negedge clk); in_ready = 1'b0; #1;
      n_chk++; if (ca_req_cmd !== CACHE::READ || ca_req_addr !== 64'h500) begin n_fail++; $display("FAIL unk_req got cmd=%0d addr=%h exp cmd=1 addr=500", ca_req_cmd, ca_req_addr); end
      ca_respcyc = 1'b1; ca_resp_data = 64'h77;
      @(negedge clk); ca_respcyc = 1'b0; #1;
      n_chk++; if (out_ready !== 1'b1 || out_mop.dst_val.val !== 64'h77) begin n_fail++; $display("FAIL unk_out got rdy=%b dst=%h exp rdy=1 dst=77", out_ready, out_mop.dst_val.val); end
      n_chk++; if (badop !== 1'b0) begin n_fail++; $display("FAIL unk_badop got %b exp 0", badop); end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single_load();
      test_fill_order();
      test_back_pressure();
      test_simul_enq_deq();
      test_reset_mid_request();
`ifdef MPIPE_BADOP_TRAP_EN
      test_badop();
`else
      test_unknown_opcode();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule
